// File: rtl/gpio_bus_arbiter_pkg.sv
// gpio_arb_pkg: shared types and constants for the GPIO header arbiter.
//   state_t   - arbiter state (IDLE, DRIVE, TURN)
//   N_REQ     - number of requesters sharing the header
//   LANE_W    - width of one output-enable lane
//   lanes()   - number of byte lanes in a header of a given width
package gpio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam int N_REQ  = 2;
  localparam int LANE_W = 8;

  function automatic int lanes(input int gpio_w);
    return gpio_w / LANE_W;
  endfunction

endpackage

// File: rtl/gpio_sync2.sv
// gpio_sync2: two-flop synchronizer for asynchronous header inputs.
//   clk     - sampling clock
//   resetn  - synchronous active-low reset, clears both stages
//   d       - asynchronous input
//   q       - synchronized output, two cycles behind d
module gpio_sync2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_r;
  logic [W-1:0] sync_r;

  // Two back-to-back sampling stages; the first may go metastable.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta_r <= {W{1'b0}};
      sync_r <= {W{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter: shares a bidirectional GPIO header between two requesters.
// Ownership is granted round-robin; the owner drives only its enabled byte
// lanes, and every change of owner passes through TURN_CYCLES all-Z cycles.
//   CLOCK_50           - system clock (rising edge)
//   resetn             - synchronous active-low reset
//   req                - request, bit i for requester i
//   wdata0/wdata1      - data each requester places on the header
//   lane_oe0/lane_oe1  - per-byte output enables of each requester
//   gnt                - registered one-hot grant
//   busy               - arbiter not idle
//   gpio_in            - header value through a two-flop synchronizer
//   GPIO               - header pins
module gpio_bus_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int GPIO_W      = 32,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_HOLD    = 16
) (
  input  logic                     CLOCK_50,
  input  logic                     resetn,
  input  logic [N_REQ-1:0]         req,
  input  logic [GPIO_W-1:0]        wdata0,
  input  logic [GPIO_W-1:0]        wdata1,
  input  logic [GPIO_W/LANE_W-1:0] lane_oe0,
  input  logic [GPIO_W/LANE_W-1:0] lane_oe1,
  output logic [N_REQ-1:0]         gnt,
  output logic                     busy,
  output logic [GPIO_W-1:0]        gpio_in,
  inout  wire  [GPIO_W-1:0]        GPIO
);

  localparam int LANES = lanes(GPIO_W);
  localparam int HW    = $clog2(MAX_HOLD) + 1;
  localparam int TW    = $clog2(TURN_CYCLES) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);

  state_t            state_r, state_nxt_s;
  logic              owner_r, owner_nxt_s;
  logic              last_r, last_nxt_s;
  logic [HW-1:0]     hold_cnt_r, hold_nxt_s;
  logic [TW-1:0]     turn_cnt_r, turn_nxt_s;
  logic [N_REQ-1:0]  gnt_r, gnt_nxt_s;
  logic              busy_r;
  logic              win_s;
  logic              other_s;
  logic [LANES-1:0]  lane_en_s;
  logic [GPIO_W-1:0] lane_data_s;

  // Round-robin pick: the requester that did not own the bus last time wins.
  assign win_s   = req[~last_r] ? ~last_r : last_r;
  assign other_s = ~owner_r;

  // Next-state, owner and counter logic.
  always_comb begin
    state_nxt_s = state_r;
    owner_nxt_s = owner_r;
    last_nxt_s  = last_r;
    hold_nxt_s  = hold_cnt_r;
    turn_nxt_s  = turn_cnt_r;
    case (state_r)
      IDLE: begin
        if (|req) begin
          state_nxt_s = DRIVE;
          owner_nxt_s = win_s;
          hold_nxt_s  = {HW{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRIVE: begin
        // Release on owner drop, or when the waiting peer has hit the hold limit.
        if (!req[owner_r] || (req[other_s] && (hold_cnt_r == HOLD_LAST))) begin
          state_nxt_s = TURN;
          last_nxt_s  = owner_r;
          turn_nxt_s  = {TW{1'b0}};
        end else if (req[other_s]) begin
          // Below the limit here, so the count saturates without an extra test.
          hold_nxt_s = hold_cnt_r + HW'(1'b1);
        end else begin
          hold_nxt_s = hold_cnt_r;
        end
      end
      TURN: begin
        if (turn_cnt_r == TURN_LAST) begin
          if (|req) begin
            state_nxt_s = DRIVE;
            owner_nxt_s = win_s;
            hold_nxt_s  = {HW{1'b0}};
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          turn_nxt_s = turn_cnt_r + TW'(1'b1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Grant follows the next state so it is available as a plain register.
  always_comb begin
    gnt_nxt_s = 2'b00;
    if (state_nxt_s == DRIVE) begin
      gnt_nxt_s = owner_nxt_s ? 2'b10 : 2'b01;
    end else begin
      gnt_nxt_s = 2'b00;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_r    <= IDLE;
      owner_r    <= 1'b0;
      last_r     <= 1'b1;
      hold_cnt_r <= {HW{1'b0}};
      turn_cnt_r <= {TW{1'b0}};
      gnt_r      <= 2'b00;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      owner_r    <= owner_nxt_s;
      last_r     <= last_nxt_s;
      hold_cnt_r <= hold_nxt_s;
      turn_cnt_r <= turn_nxt_s;
      gnt_r      <= gnt_nxt_s;
      busy_r     <= (state_nxt_s != IDLE);
    end
  end

  assign gnt  = gnt_r;
  assign busy = busy_r;

  // Owner data and enables pass straight through while driving.
  always_comb begin
    lane_en_s   = {LANES{1'b0}};
    lane_data_s = wdata0;
    if (state_r == DRIVE) begin
      lane_en_s   = owner_r ? lane_oe1 : lane_oe0;
      lane_data_s = owner_r ? wdata1 : wdata0;
    end else begin
      lane_en_s   = {LANES{1'b0}};
      lane_data_s = wdata0;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign GPIO[k*LANE_W +: LANE_W] = lane_en_s[k] ? lane_data_s[k*LANE_W +: LANE_W]
                                                   : {LANE_W{1'bz}};
  end

  gpio_sync2 #(
    .W(GPIO_W)
  ) u_sync (
    .clk    (CLOCK_50),
    .resetn (resetn),
    .d      (GPIO),
    .q      (gpio_in)
  );

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Self-checking bench for gpio_bus_arbiter. Header pins carry pull-ups, so an
// undriven lane reads back as 8'hFF.
module tb_gpio_bus_arbiter;

  localparam int GPIO_W      = 32;
  localparam int TURN_CYCLES = 1;
  localparam int MAX_HOLD    = 16;

  logic        CLOCK_50;
  logic        resetn;
  logic [1:0]  req;
  logic [31:0] wdata0, wdata1;
  logic [3:0]  lane_oe0, lane_oe1;
  wire  [1:0]  gnt;
  wire         busy;
  wire  [31:0] gpio_in;
  wire  [31:0] GPIO;
  logic        ext_oe;
  logic [31:0] ext_val;

  assign GPIO = ext_oe ? ext_val : 32'hzzzz_zzzz;
  for (genvar i = 0; i < GPIO_W; i++) begin : g_pu
    pullup (GPIO[i]);
  end

  gpio_bus_arbiter #(
    .GPIO_W(GPIO_W), .TURN_CYCLES(TURN_CYCLES), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .req(req),
    .wdata0(wdata0), .wdata1(wdata1), .lane_oe0(lane_oe0), .lane_oe1(lane_oe1),
    .gnt(gnt), .busy(busy), .gpio_in(gpio_in), .GPIO(GPIO)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  // Behavioural model: who owns the header, how many quiet cycles remain
  // before a new owner may take it, and how long the other side has waited.
  int          m_owner;   // -1: nobody owns the header
  int          m_gap;     // remaining all-Z turnaround cycles
  int          m_wait;    // cycles the non-owner has waited (capped)
  int          m_last;    // previous owner
  logic [31:0] m_s1, m_s2;
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          chk_en   = 1'b0;

  function automatic logic [31:0] exp_bus();
    logic [31:0] v;
    logic [3:0]  oe;
    logic [31:0] d;
    oe = (m_owner == 1) ? lane_oe1 : lane_oe0;
    d  = (m_owner == 1) ? wdata1 : wdata0;
    for (int k = 0; k < 4; k++) begin
      if (m_owner >= 0 && oe[k])
        v[k*8 +: 8] = d[k*8 +: 8];
      else if (ext_oe)
        v[k*8 +: 8] = ext_val[k*8 +: 8];
      else
        v[k*8 +: 8] = 8'hFF;
    end
    return v;
  endfunction

  function automatic logic [1:0] exp_gnt();
    if (m_owner == 0) return 2'b01;
    if (m_owner == 1) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int pick();
    return req[1 - m_last] ? (1 - m_last) : m_last;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  // Advance the model at each rising edge using the inputs the DUT also sees.
  initial forever begin
    @(posedge CLOCK_50);
    if (!resetn) begin
      m_owner = -1; m_gap = 0; m_wait = 0; m_last = 1;
      m_s1 = 32'h0; m_s2 = 32'h0;
    end else begin
      m_s2 = m_s1;
      m_s1 = exp_bus();
      if (m_owner >= 0) begin
        if (!req[m_owner] || (req[1 - m_owner] && m_wait >= MAX_HOLD - 1)) begin
          m_last  = m_owner;
          m_owner = -1;
          m_gap   = TURN_CYCLES;
        end else if (req[1 - m_owner]) begin
          m_wait++;
        end
      end else if (m_gap > 0) begin
        m_gap--;
        if (m_gap == 0 && req != 2'b00) begin
          m_owner = pick(); m_wait = 0;
        end
      end else if (req != 2'b00) begin
        m_owner = pick(); m_wait = 0;
      end
    end
  end

  // Cycle-by-cycle comparison on the falling edge.
  initial forever begin
    @(negedge CLOCK_50);
    if (chk_en) begin
      check("gnt",     {30'h0, gnt}, {30'h0, exp_gnt()});
      check("busy",    {31'h0, busy}, {31'h0, (m_owner >= 0 || m_gap > 0)});
      check("gpio_in", gpio_in, m_s2);
      check("GPIO",    GPIO, exp_bus());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #2;
  endtask

  initial begin
    resetn = 1'b0; req = 2'b00; wdata0 = 32'h0; wdata1 = 32'h0;
    lane_oe0 = 4'h0; lane_oe1 = 4'h0; ext_oe = 1'b0; ext_val = 32'h0;

    // Reset then idle
    tick(1); chk_en = 1'b1; tick(2);
    check("rst_gnt", {30'h0, gnt}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_gpio_in", gpio_in, 32'h0);
    check("rst_GPIO", GPIO, 32'hFFFF_FFFF);
    resetn = 1'b1; tick(1);

    // Single owner, partial lanes
    wdata0 = 32'hA5C3_1E77; lane_oe0 = 4'b0101; req = 2'b01;
    tick(1);
    check("single_gnt", {30'h0, gnt}, 32'h1);
    check("single_GPIO", GPIO, 32'hFFC3_FF77);
    tick(2);
    check("single_gpio_in", gpio_in, 32'hFFC3_FF77);
    req = 2'b00; tick(1);
    check("single_turn_busy", {31'h0, busy}, 32'h1);
    tick(1);
    check("single_idle_busy", {31'h0, busy}, 32'h0);

    // Tie and turnaround, starting from reset so requester 0 wins the tie
    resetn = 1'b0; tick(1); resetn = 1'b1;
    wdata1 = 32'h3C5A_9612; lane_oe1 = 4'b1010; req = 2'b11;
    tick(1);
    check("tie_gnt", {30'h0, gnt}, 32'h1);
    tick(3); req = 2'b10; tick(1);
    check("tie_turn_gnt", {30'h0, gnt}, 32'h0);
    check("tie_turn_GPIO", GPIO, 32'hFFFF_FFFF);
    tick(1);
    check("tie_next_gnt", {30'h0, gnt}, 32'h2);
    check("tie_next_GPIO", GPIO, 32'h3CFF_96FF);

    // Forced release: owner 1 keeps the bus 16 cycles once requester 0 waits
    req = 2'b11;
    for (int i = 0; i < 16; i++) begin
      check("hold1_gnt", {30'h0, gnt}, 32'h2);
      tick(1);
    end
    check("hold1_turn_gnt", {30'h0, gnt}, 32'h0);
    check("hold1_turn_GPIO", GPIO, 32'hFFFF_FFFF);
    tick(1);
    check("hold1_next_gnt", {30'h0, gnt}, 32'h1);
    // Reverse direction
    for (int i = 0; i < 15; i++) begin
      tick(1);
      check("hold0_gnt", {30'h0, gnt}, 32'h1);
    end
    tick(1);
    check("hold0_turn_gnt", {30'h0, gnt}, 32'h0);
    tick(1);
    check("hold0_next_gnt", {30'h0, gnt}, 32'h2);

    // Reset mid-drive
    resetn = 1'b0; tick(1);
    check("mid_rst_gnt", {30'h0, gnt}, 32'h0);
    check("mid_rst_GPIO", GPIO, 32'hFFFF_FFFF);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    resetn = 1'b1; tick(1);
    check("post_rst_gnt", {30'h0, gnt}, 32'h1);
    req = 2'b00; tick(2);
    check("post_rst_idle", {31'h0, busy}, 32'h0);

    // External input
    lane_oe0 = 4'h0; lane_oe1 = 4'h0;
    ext_val = 32'h1234_5678; ext_oe = 1'b1; #1;
    check("ext_GPIO", GPIO, 32'h1234_5678);
    tick(1);
    check("ext_gpio_in_1", gpio_in, 32'hFFFF_FFFF);
    tick(1);
    check("ext_gpio_in_2", gpio_in, 32'h1234_5678);
    ext_oe = 1'b0; tick(2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
